// File: rtl/rr_mux_arbiter_if.sv
// Bundle between the requester bank, the round-robin arbiter and the single consumer.
// Handshake: a word moves when out_valid & out_ready are both high at a rising clk edge; ack[sel] mirrors that cycle.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         req;
  logic [8*WIDTH-1:0] data;
  logic [7:0]         lock;
  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         sel;
  logic [7:0]         gnt;
  logic [7:0]         ack;
  logic               dbg_state;

  modport master (
    output req, data, lock, out_ready,
    input  out_valid, out_data, sel, gnt, ack, dbg_state
  );

  modport slave (
    input  req, data, lock, out_ready,
    output out_valid, out_data, sel, gnt, ack, dbg_state
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select onto one valid/ready output channel.
// Define ARB_LOCK_EN to let a locked requester stream back-to-back words without re-arbitration.
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  rr_mux_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_sel;
  logic [7:0] r_gnt;
  logic       r_valid;

  logic       w_found;
  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_xfer;
  logic       w_lock_hold;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_idx = r_ptr + 3'(k);
      if (bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_xfer = r_valid & bus.out_ready;

`ifdef ARB_LOCK_EN
  assign w_lock_hold = bus.lock[r_sel] & bus.req[r_sel];
`else
  assign w_lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel   <= w_winner;
            r_gnt   <= 8'b1 << w_winner;
            r_valid <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // A locked transfer keeps the grant and leaves the pointer alone.
          if (w_xfer && !w_lock_hold) begin
            r_ptr   <= r_sel + 3'd1;
            r_gnt   <= 8'd0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 8'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = bus.data[r_sel*WIDTH +: WIDTH];
  assign bus.sel       = r_sel;
  assign bus.gnt       = r_gnt;
  assign bus.ack       = w_xfer ? (8'b1 << r_sel) : 8'd0;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed stimulus pushes expected {sel,data}, a monitor pops on each transfer.
module tb_rr_mux_arbiter;
  localparam int WIDTH = 8;
  localparam int W     = 3 + WIDTH;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   gap_chk;
  int   last_ack_cyc;

  logic [W-1:0] exp_q[$];
  logic [WIDTH-1:0] slot_val[8];

  rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s);
    logic [2:0] s3;
    s3 = 3'(s);
    exp_q.push_back({s3, slot_val[s]});
  endtask

  task automatic load_data();
    for (int i = 0; i < 8; i++) bus.data[i*WIDTH +: WIDTH] = slot_val[i];
  endtask

  // Waits until every expected transfer has been observed and its completing edge has passed.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("ack_without_valid", {31'd0, (bus.ack == 8'd0) || bus.out_valid}, 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer actual_sel=%0d expected=none", bus.sel);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_sel", {29'd0, bus.sel}, {29'd0, e[W-1 -: 3]});
        chk("xfer_data", {24'd0, bus.out_data}, {24'd0, e[WIDTH-1:0]});
        chk("xfer_ack", {24'd0, bus.ack}, {24'd0, 8'b1 << e[W-1 -: 3]});
        chk("xfer_gnt", {24'd0, bus.gnt}, {24'd0, 8'b1 << e[W-1 -: 3]});
        if (gap_chk != 0 && last_ack_cyc >= 0)
          chk("ack_spacing", cyc - last_ack_cyc, gap_chk);
        last_ack_cyc = cyc;
      end
    end
  end

  // Driver
  initial begin
    checks       = 0;
    failures     = 0;
    gap_chk      = 0;
    last_ack_cyc = -1;
    slot_val     = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    rst_n         = 1'b0;
    bus.req       = 8'hFF;
    bus.lock      = 8'h00;
    bus.out_ready = 1'b1;
    load_data();

    // Reset state with every requester asking
    repeat (3) @(negedge clk);
    chk("rst_gnt", {24'd0, bus.gnt}, 32'h0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'h0);
    chk("rst_ack", {24'd0, bus.ack}, 32'h0);
    chk("rst_sel", {29'd0, bus.sel}, 32'h0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'h10);

    // Round robin 0..7 then wrap to 0, one ack every 2 cycles
    for (int i = 0; i < 8; i++) push_exp(i);
    push_exp(0);
    gap_chk      = 2;
    last_ack_cyc = -1;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    chk("first_gnt", {24'd0, bus.gnt}, 32'h01);
    wait_drain(60);
    bus.req = 8'h00;
    gap_chk = 0;

    // Pointer skip: after requester 5, pattern 0010_0100 goes to 2
    bus.req = 8'h20;
    push_exp(5);
    wait_drain(20);
    bus.req = 8'b0010_0100;
    push_exp(2);
    wait_drain(20);
    bus.req = 8'h00;

    // Backpressure on requester 3
    slot_val[3] = 8'hA5;
    load_data();
    bus.out_ready = 1'b0;
    bus.req       = 8'h08;
    push_exp(3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'h1);
      chk("bp_data", {24'd0, bus.out_data}, 32'hA5);
      chk("bp_sel", {29'd0, bus.sel}, 32'h3);
      chk("bp_ack", {24'd0, bus.ack}, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain(10);
    bus.req = 8'h00;
    @(negedge clk);
    chk("bp_ack_one_cycle", {24'd0, bus.ack}, 32'h0);
    chk("bp_valid_drop", {31'd0, bus.out_valid}, 32'h0);

    // Asynchronous reset while requester 6 is granted and stalled
    bus.out_ready = 1'b0;
    bus.req       = 8'h40;
    @(posedge clk);
    #1;
    chk("ar_busy_gnt", {24'd0, bus.gnt}, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", {31'd0, bus.out_valid}, 32'h0);
    chk("ar_gnt_drop", {24'd0, bus.gnt}, 32'h0);
    chk("ar_ack", {24'd0, bus.ack}, 32'h0);
    bus.req       = 8'h00;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer back at 0: requester 0 beats 7
    bus.req = 8'h81;
    push_exp(0);
    wait_drain(20);
    bus.req = 8'h00;

`ifdef ARB_LOCK_EN
    // Locked requester 4 streams three words, then 5 follows
    bus.req      = 8'h10;
    bus.lock     = 8'h10;
    gap_chk      = 1;
    last_ack_cyc = -1;
    push_exp(4);
    push_exp(4);
    push_exp(4);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.lock = 8'h00;
    bus.req  = 8'h30;
    wait_drain(10);
    gap_chk = 0;
    push_exp(5);
    wait_drain(10);
    bus.req = 8'h00;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
